// File: rtl/mem_cmd_arbiter_pkg.sv
// Shared definitions for the memory command arbiter: payload layout,
// FSM state encoding and source identifiers.
package mem_cmd_arbiter_pkg;

  localparam int PAYLOAD_W = 22;

  // Field offsets inside a packed command:
  // {move_dir, msg_type, block_x, block_y, card, sel_len}
  localparam int SEL_LEN_LSB  = 0;
  localparam int CARD_LSB     = 3;
  localparam int BLOCK_Y_LSB  = 9;
  localparam int BLOCK_X_LSB  = 12;
  localparam int MSG_TYPE_LSB = 17;
  localparam int MOVE_DIR_LSB = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic SRC_LOCAL  = 1'b0;
  localparam logic SRC_REMOTE = 1'b1;

  function automatic logic [PAYLOAD_W-1:0] pack_cmd(
    input logic       move_dir,
    input logic [3:0] msg_type,
    input logic [4:0] block_x,
    input logic [2:0] block_y,
    input logic [5:0] card,
    input logic [2:0] sel_len
  );
    return {move_dir, msg_type, block_x, block_y, card, sel_len};
  endfunction

endpackage

// File: rtl/mem_cmd_arbiter_fifo.sv
// Small synchronous FIFO holding packed commands for one source.
// Pointers carry one extra wrap bit so full/empty need no counter.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // A push while full is dropped; flush wins over both push and pop.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update: reset and flush both return to empty.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Serializes local and remote memory commands toward MemoryHandle:
// per-source FIFOs, round-robin grant, one-cycle issue strobe and a
// bounded wait for the completion pulse.
module mem_cmd_arbiter
  import mem_cmd_arbiter_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic       ctrl_move_dir,
  input  logic [3:0] ctrl_msg_type,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       interboard_rst,
  input  logic       interboard_en,
  input  logic       interboard_move_dir,
  input  logic [3:0] interboard_msg_type,
  input  logic [4:0] interboard_block_x,
  input  logic [2:0] interboard_block_y,
  input  logic [5:0] interboard_card,
  input  logic [2:0] interboard_sel_len,
  input  logic       mem_done,
  output logic       mem_en,
  output logic       mem_src,
  output logic       mem_move_dir,
  output logic [3:0] mem_msg_type,
  output logic [4:0] mem_block_x,
  output logic [2:0] mem_block_y,
  output logic [5:0] mem_card,
  output logic [2:0] mem_sel_len,
  output logic       ctrl_full,
  output logic       ib_full,
  output logic       ovf_err,
  output logic       tmo_err,
  output logic       busy
);

  state_t                 state;
  state_t                 state_next;
  logic                   rr_ptr;
  logic [TW-1:0]          tmo_cnt;
  logic [PAYLOAD_W-1:0]   issued;
  logic [PAYLOAD_W-1:0]   l_din;
  logic [PAYLOAD_W-1:0]   r_din;
  logic [PAYLOAD_W-1:0]   l_dout;
  logic [PAYLOAD_W-1:0]   r_dout;
  logic                   l_empty;
  logic                   r_empty;
  logic                   grant_l;
  logic                   grant_r;
  logic                   tmo_hit;

  assign l_din = pack_cmd(ctrl_move_dir, ctrl_msg_type, ctrl_block_x,
                          ctrl_block_y, ctrl_card, ctrl_sel_len);
  assign r_din = pack_cmd(interboard_move_dir, interboard_msg_type, interboard_block_x,
                          interboard_block_y, interboard_card, interboard_sel_len);

  // Strobes coinciding with a remote flush are discarded via the flush input.
  cmd_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_local_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ctrl_en),
    .pop   (grant_l),
    .flush (interboard_rst),
    .din   (l_din),
    .dout  (l_dout),
    .full  (ctrl_full),
    .empty (l_empty)
  );

  cmd_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_remote_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (interboard_en),
    .pop   (grant_r),
    .flush (interboard_rst),
    .din   (r_din),
    .dout  (r_dout),
    .full  (ib_full),
    .empty (r_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state and grant decision; rr_ptr names the preferred source
  // when both FIFOs hold work.
  always_comb begin
    state_next = state;
    grant_l    = 1'b0;
    grant_r    = 1'b0;
    tmo_hit    = 1'b0;
    if (interboard_rst) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!l_empty && (r_empty || rr_ptr == SRC_LOCAL)) begin
            grant_l    = 1'b1;
            state_next = ST_ISSUE;
          end else if (!r_empty) begin
            grant_r    = 1'b1;
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: state_next = ST_WAIT;
        ST_WAIT: begin
          if (mem_done) begin
            state_next = ST_IDLE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            tmo_hit    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: issued payload, round-robin pointer, timeout counter, sticky errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr  <= SRC_LOCAL;
      tmo_cnt <= '0;
      issued  <= '0;
      mem_src <= SRC_LOCAL;
      ovf_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      if (!interboard_rst && ((ctrl_en && ctrl_full) || (interboard_en && ib_full)))
        ovf_err <= 1'b1;
      if (tmo_hit)
        tmo_err <= 1'b1;
      if (interboard_rst)  rr_ptr <= SRC_LOCAL;
      else if (grant_l)    rr_ptr <= SRC_REMOTE;
      else if (grant_r)    rr_ptr <= SRC_LOCAL;
      if (grant_l || grant_r) begin
        mem_src <= grant_r ? SRC_REMOTE : SRC_LOCAL;
        issued  <= grant_r ? r_dout : l_dout;
      end
      if (state == ST_ISSUE)     tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign mem_en       = (state == ST_ISSUE) && !interboard_rst;
  assign mem_move_dir = issued[MOVE_DIR_LSB];
  assign mem_msg_type = issued[MSG_TYPE_LSB +: 4];
  assign mem_block_x  = issued[BLOCK_X_LSB +: 5];
  assign mem_block_y  = issued[BLOCK_Y_LSB +: 3];
  assign mem_card     = issued[CARD_LSB +: 6];
  assign mem_sel_len  = issued[SEL_LEN_LSB +: 3];
  assign busy         = (state != ST_IDLE) || !l_empty || !r_empty;

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed bench for mem_cmd_arbiter: expected issues go into a queue at
// stimulus time, a monitor pops and compares on every mem_en pulse.
module tb_mem_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ctrl_en = 1'b0, ctrl_move_dir = 1'b0;
  logic [3:0] ctrl_msg_type = '0;
  logic [4:0] ctrl_block_x = '0;
  logic [2:0] ctrl_block_y = '0;
  logic [5:0] ctrl_card = '0;
  logic [2:0] ctrl_sel_len = '0;
  logic       interboard_rst = 1'b0, interboard_en = 1'b0, interboard_move_dir = 1'b0;
  logic [3:0] interboard_msg_type = '0;
  logic [4:0] interboard_block_x = '0;
  logic [2:0] interboard_block_y = '0;
  logic [5:0] interboard_card = '0;
  logic [2:0] interboard_sel_len = '0;
  logic       mem_done = 1'b0;
  logic       mem_en, mem_src, mem_move_dir;
  logic [3:0] mem_msg_type;
  logic [4:0] mem_block_x;
  logic [2:0] mem_block_y;
  logic [5:0] mem_card;
  logic [2:0] mem_sel_len;
  logic       ctrl_full, ib_full, ovf_err, tmo_err, busy;

  mem_cmd_arbiter #(.DEPTH(4), .TIMEOUT(15), .TW(4)) dut (
    .clk(clk), .rst(rst),
    .ctrl_en(ctrl_en), .ctrl_move_dir(ctrl_move_dir), .ctrl_msg_type(ctrl_msg_type),
    .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y), .ctrl_card(ctrl_card),
    .ctrl_sel_len(ctrl_sel_len),
    .interboard_rst(interboard_rst), .interboard_en(interboard_en),
    .interboard_move_dir(interboard_move_dir), .interboard_msg_type(interboard_msg_type),
    .interboard_block_x(interboard_block_x), .interboard_block_y(interboard_block_y),
    .interboard_card(interboard_card), .interboard_sel_len(interboard_sel_len),
    .mem_done(mem_done), .mem_en(mem_en), .mem_src(mem_src), .mem_move_dir(mem_move_dir),
    .mem_msg_type(mem_msg_type), .mem_block_x(mem_block_x), .mem_block_y(mem_block_y),
    .mem_card(mem_card), .mem_sel_len(mem_sel_len), .ctrl_full(ctrl_full), .ib_full(ib_full),
    .ovf_err(ovf_err), .tmo_err(tmo_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_en = 0;
  int done_delay = 0;        // 0: never answer; k: mem_done k cycles after mem_en
  logic [22:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [21:0] pk(input bit md, input int mt, input int bx,
                                     input int by, input int cd, input int sl);
    logic [3:0] m; logic [4:0] x; logic [2:0] y; logic [5:0] c; logic [2:0] s;
    m = mt[3:0]; x = bx[4:0]; y = by[2:0]; c = cd[5:0]; s = sl[2:0];
    return {md, m, x, y, c, s};
  endfunction

  // Monitor: every issue must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_en) begin
      n_en++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL issue_unexpected: got %0h expected none (cycle %0d)",
                 {mem_src, mem_move_dir, mem_msg_type, mem_block_x, mem_block_y, mem_card, mem_sel_len}, cyc);
      end else begin
        chk("issue", {9'd0, mem_src, mem_move_dir, mem_msg_type, mem_block_x, mem_block_y,
                      mem_card, mem_sel_len}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  // MemoryHandle model: answers done_delay cycles after each issue.
  initial forever begin
    @(negedge clk);
    if (mem_en && done_delay > 0) begin
      repeat (done_delay) @(negedge clk);
      mem_done = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
    end
  end

  // One strobe cycle on either/both sources; optionally expect the issue.
  task automatic strobe(input bit l, input logic [21:0] pl, input bit el,
                        input bit r, input logic [21:0] pr, input bit er);
    ctrl_en = l;
    {ctrl_move_dir, ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len} = pl;
    interboard_en = r;
    {interboard_move_dir, interboard_msg_type, interboard_block_x, interboard_block_y,
     interboard_card, interboard_sel_len} = pr;
    if (l && el) exp_q.push_back({1'b0, pl});
    if (r && er) exp_q.push_back({1'b1, pr});
    @(negedge clk);
    ctrl_en = 1'b0;
    interboard_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int base;
  logic [21:0] z = '0;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_flags", {27'd0, busy, ctrl_full, ib_full, ovf_err, tmo_err}, 0);
    chk("rst_payload", {9'd0, mem_src, mem_move_dir, mem_msg_type, mem_block_x, mem_block_y,
                        mem_card, mem_sel_len}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single local command, done 3 cycles after issue
    done_delay = 3; base = n_en;
    strobe(1, pk(1, 3, 5, 2, 17, 4), 1, 0, z, 0);
    @(negedge clk);
    chk("t1_latency_en", {31'd0, mem_en}, 1);
    chk("t1_src", {31'd0, mem_src}, 0);
    chk("t1_card", {26'd0, mem_card}, 17);
    @(negedge clk);
    chk("t1_pulse_width", {31'd0, mem_en}, 0);
    repeat (2) @(negedge clk);
    chk("t1_busy_before_done", {31'd0, busy}, 1);
    @(negedge clk);
    chk("t1_busy_after_done", {31'd0, busy}, 0);
    chk("t1_card_held", {26'd0, mem_card}, 17);
    chk("t1_count", n_en - base, 1);

    // Pointer back to local, then 3 simultaneous pairs, immediate done
    interboard_rst = 1'b1; @(negedge clk); interboard_rst = 1'b0;
    done_delay = 1; base = n_en;
    strobe(1, pk(0, 1, 1, 1, 1, 1), 1, 1, pk(1, 9, 21, 5, 33, 2), 1);
    strobe(1, pk(0, 2, 2, 2, 2, 2), 1, 1, pk(1, 10, 22, 6, 34, 3), 1);
    strobe(1, pk(0, 3, 3, 3, 3, 3), 1, 1, pk(1, 11, 23, 7, 35, 4), 1);
    wait_idle("t2_idle");
    chk("t2_count", n_en - base, 6);

    // Overflow during WAIT, then timeout of the command in service
    done_delay = 0; base = n_en;
    strobe(1, pk(0, 4, 10, 1, 40, 0), 1, 0, z, 0);
    @(negedge clk);
    chk("t3_en", {31'd0, mem_en}, 1);
    strobe(1, pk(0, 5, 11, 2, 41, 1), 1, 0, z, 0);
    strobe(1, pk(0, 6, 12, 3, 42, 2), 1, 0, z, 0);
    strobe(1, pk(0, 7, 13, 4, 43, 3), 1, 0, z, 0);
    strobe(1, pk(0, 8, 14, 5, 44, 4), 1, 0, z, 0);
    chk("t3_full_at_4", {30'd0, ctrl_full, ovf_err}, 2);
    strobe(1, pk(1, 15, 31, 7, 63, 7), 0, 0, z, 0);
    chk("t3_ovf", {30'd0, ctrl_full, ovf_err}, 3);
    done_delay = 1;
    repeat (10) @(negedge clk);
    chk("t4_no_tmo_yet", {30'd0, tmo_err, mem_en}, 0);
    @(negedge clk);
    chk("t4_tmo_at_16", {30'd0, tmo_err, ctrl_full}, 3);
    @(negedge clk);
    chk("t4_next_issue", {31'd0, mem_en}, 1);
    wait_idle("t3_idle");
    chk("t3_count", n_en - base, 5);

    // interboard_rst during WAIT with 3 queued; same-cycle strobe discarded
    done_delay = 0; base = n_en;
    strobe(1, pk(1, 12, 7, 3, 20, 5), 1, 0, z, 0);
    @(negedge clk);
    strobe(0, z, 0, 1, pk(0, 1, 2, 3, 4, 5), 0);
    strobe(0, z, 0, 1, pk(0, 2, 3, 4, 5, 6), 0);
    strobe(1, pk(0, 3, 4, 5, 6, 7), 0, 0, z, 0);
    interboard_rst = 1'b1;
    strobe(1, pk(1, 1, 1, 1, 1, 1), 0, 0, z, 0);
    interboard_rst = 1'b0;
    chk("t5_flushed", {28'd0, busy, ctrl_full, ib_full, mem_en}, 0);
    chk("t5_sticky_kept", {30'd0, ovf_err, tmo_err}, 3);
    repeat (25) @(negedge clk);
    chk("t5_no_more_issue", n_en - base, 1);
    done_delay = 1;
    strobe(0, z, 0, 1, pk(1, 6, 9, 2, 50, 1), 1);
    @(negedge clk);
    chk("t5_new_issue", {30'd0, mem_en, mem_src}, 3);
    wait_idle("t5_idle");

    // rst mid-WAIT with both FIFOs holding work
    done_delay = 0; base = n_en;
    strobe(1, pk(0, 9, 8, 1, 12, 3), 1, 0, z, 0);
    @(negedge clk);
    strobe(1, pk(0, 1, 0, 0, 1, 0), 0, 1, pk(1, 2, 0, 0, 2, 0), 0);
    strobe(1, pk(0, 3, 0, 0, 3, 0), 0, 0, z, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_flags", {27'd0, busy, ctrl_full, ib_full, ovf_err, tmo_err}, 0);
    chk("t6_rst_outs", {9'd0, mem_en, mem_src, mem_msg_type, mem_block_x, mem_block_y,
                        mem_card, mem_sel_len}, 0);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("t6_no_issue", n_en - base, 1);
    done_delay = 1;
    strobe(1, pk(1, 4, 17, 6, 29, 2), 1, 0, z, 0);
    wait_idle("t6_idle");
    chk("t6_count", n_en - base, 2);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
